// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift per clock.
// state | meaning: IDLE wait for start | SHIFT shift+correct BIN_W times | DONE result latched, pulse done next
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_sh;
  logic [WORK_W-1:0] work_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Subtract 3 from every shifted BCD nibble >= 8 (add 4'b1101, carry dropped).
  always_comb begin
    work_sh  = work >> 1;
    work_nxt = work_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_sh[BIN_W + 4*i + 3]) begin
        work_nxt[BIN_W + 4*i +: 4] = work_sh[BIN_W + 4*i +: 4] + 4'b1101;
      end
    end
  end

  // done is registered on the edge leaving DONE, so it lags the DONE state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
      work    <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              err     <= 1'b1;
              bin_out <= '0;
              state   <= DONE;
            end else begin
              work  <= {bcd_in, {BIN_W{1'b0}}};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bin_out <= work_nxt[BIN_W-1:0];
            err     <= 1'b0;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] bin_out;

  int n_cmp = 0;
  int n_mis = 0;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Pulse start for one accepting edge, then watch 40 edges; lat = edge of first done (0 = none).
  task automatic run_conv(input logic [15:0] b, output int lat, output logic [13:0] r,
                          output logic e, output int pulses);
    lat = 0; pulses = 0; r = '0; e = 1'b0;
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = n; r = bin_out; e = err;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bcd_in = '0;
    #23;
    n_cmp++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      n_mis++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b bin=%0d, want all 0", busy, done, err, bin_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      n_mis++;
      $display("FAIL idle_after_reset: got busy=%b done=%b err=%b bin=%0d, want all 0", busy, done, err, bin_out);
    end
  endtask

  task automatic test_zero();
    int lat, p; logic [13:0] r; logic e;
    run_conv(16'h0000, lat, r, e, p);
    n_cmp++;
    if (lat !== 15 || p !== 1) begin
      n_mis++;
      $display("FAIL zero_latency: got lat=%0d pulses=%0d, want lat=15 pulses=1", lat, p);
    end
    n_cmp++;
    if (r !== 14'd0 || e !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_result: got bin=%0d err=%b, want 0 err=0", r, e);
    end
  endtask

  task automatic test_values();
    logic [15:0] vin [6] = '{16'h9999, 16'h1234, 16'h0001, 16'h8000, 16'h0909, 16'h0088};
    logic [13:0] vexp [6] = '{14'd9999, 14'd1234, 14'd1, 14'd8000, 14'd909, 14'd88};
    int lat, p; logic [13:0] r; logic e;
    for (int i = 0; i < 6; i++) begin
      run_conv(vin[i], lat, r, e, p);
      n_cmp++;
      if (r !== vexp[i] || e !== 1'b0 || lat !== 15 || p !== 1) begin
        n_mis++;
        $display("FAIL value_%h: got bin=%0d err=%b lat=%0d pulses=%0d, want bin=%0d err=0 lat=15 pulses=1",
                 vin[i], r, e, lat, p, vexp[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int lat, p; logic [13:0] r; logic e;
    run_conv(16'h12A4, lat, r, e, p);
    n_cmp++;
    if (lat !== 1 || p !== 1 || e !== 1'b1 || r !== 14'd0) begin
      n_mis++;
      $display("FAIL invalid_12A4: got lat=%0d pulses=%0d err=%b bin=%0d, want lat=1 pulses=1 err=1 bin=0", lat, p, e, r);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++;
      $display("FAIL err_held: got err=%b, want 1", err);
    end
    run_conv(16'h0042, lat, r, e, p);
    n_cmp++;
    if (e !== 1'b0 || r !== 14'd42 || lat !== 15) begin
      n_mis++;
      $display("FAIL after_invalid_0042: got err=%b bin=%0d lat=%0d, want err=0 bin=42 lat=15", e, r, lat);
    end
    run_conv(16'hF000, lat, r, e, p);
    n_cmp++;
    if (lat !== 1 || e !== 1'b1 || r !== 14'd0) begin
      n_mis++;
      $display("FAIL invalid_F000: got lat=%0d err=%b bin=%0d, want lat=1 err=1 bin=0", lat, e, r);
    end
  endtask

  task automatic test_ignore();
    int lat = 0, p = 0; logic [13:0] r = '0;
    @(negedge clk);
    bcd_in = 16'h0500; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        p++;
        if (lat == 0) begin lat = n; r = bin_out; end
      end
      if (n == 5) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_mis++;
          $display("FAIL busy_mid: got busy=%b, want 1", busy);
        end
        start = 1'b1; bcd_in = 16'h9999;
      end
      if (n == 8) start = 1'b0;
    end
    n_cmp++;
    if (r !== 14'd500 || p !== 1 || lat !== 15) begin
      n_mis++;
      $display("FAIL ignore_start: got bin=%0d pulses=%0d lat=%0d, want bin=500 pulses=1 lat=15", r, p, lat);
    end
  endtask

  task automatic test_abort();
    int lat, p = 0; logic [13:0] r; logic e;
    @(negedge clk);
    bcd_in = 16'h8765; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 14'd0) begin
      n_mis++;
      $display("FAIL abort_reset: got busy=%b done=%b bin=%0d, want 0 0 0", busy, done, bin_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) p++;
    end
    n_cmp++;
    if (p !== 0 || bin_out !== 14'd0) begin
      n_mis++;
      $display("FAIL abort_no_done: got pulses=%0d bin=%0d, want 0 and 0", p, bin_out);
    end
    run_conv(16'h0008, lat, r, e, p);
    n_cmp++;
    if (r !== 14'd8 || e !== 1'b0 || lat !== 15) begin
      n_mis++;
      $display("FAIL restart_0008: got bin=%0d err=%b lat=%0d, want 8 0 15", r, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    int vals [12];
    int idx = 0, edge_cnt = 0, last = 0;
    vals[0] = 0; vals[1] = 9999;
    for (int i = 2; i < 12; i++) vals[i] = int'($urandom_range(0, 9999));
    @(negedge clk);
    bcd_in = to_bcd(vals[0]); start = 1'b1;
    @(posedge clk); #1;
    while (idx < 12 && edge_cnt < 12 * 20) begin
      @(posedge clk); #1;
      edge_cnt++;
      if (done) begin
        n_cmp++;
        if (bin_out !== 14'(vals[idx]) || err !== 1'b0) begin
          n_mis++;
          $display("FAIL b2b_result_%0d: got bin=%0d err=%b, want bin=%0d err=0", idx, bin_out, err, vals[idx]);
        end
        n_cmp++;
        if ((idx == 0 && edge_cnt != 15) || (idx > 0 && edge_cnt - last != 16)) begin
          n_mis++;
          $display("FAIL b2b_spacing_%0d: got edge=%0d prev=%0d, want first=15 then spacing 16", idx, edge_cnt, last);
        end
        last = edge_cnt;
        idx++;
        if (idx < 12) bcd_in = to_bcd(vals[idx]);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (idx != 12) begin
      n_mis++;
      $display("FAIL b2b_timeout: got %0d done pulses, want 12", idx);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_invalid();
    test_ignore();
    test_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
